// File: rtl/com_slink_tx_arb_pkg.sv
// Shared constants, word layout and FSM encoding for the SLINK transmit arbiter.
package com_slink_tx_arb_pkg;

  localparam int PORT_NUM = 4;
  localparam int WORD_W   = 18;
  localparam int SOP_BIT  = 17;
  localparam int EOP_BIT  = 16;
  localparam int GAP_W    = 8;
  localparam int TOUT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  // Index of the set bit in a one-hot port vector (0 when none set).
  function automatic logic [1:0] oh_to_idx(input logic [PORT_NUM-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/com_slink_tx_arb_if.sv
// Requester-side and transmitter-side signals of the SLINK transmit arbiter.
// slave = arbiter view, master = environment view.
interface com_slink_tx_arb_if;
  import com_slink_tx_arb_pkg::*;

  logic [PORT_NUM-1:0]        port_en;
  logic [PORT_NUM-1:0]        req_empty;
  logic [PORT_NUM-1:0]        req_rdreq;
  logic [PORT_NUM*WORD_W-1:0] req_data;
  logic [PORT_NUM-1:0]        req_dval;
  logic                       tx_rdreq;
  logic [WORD_W-1:0]          tx_data;
  logic                       tx_dval;
  logic                       tx_empty;
  logic [PORT_NUM-1:0]        grant;
  logic                       tx_eop;
  logic                       arb_err;

  modport master (
    output port_en, req_empty, req_data, req_dval, tx_rdreq,
    input  req_rdreq, tx_data, tx_dval, tx_empty, grant, tx_eop, arb_err
  );

  modport slave (
    input  port_en, req_empty, req_data, req_dval, tx_rdreq,
    output req_rdreq, tx_data, tx_dval, tx_empty, grant, tx_eop, arb_err
  );

endinterface

// File: rtl/com_rr_arb4.sv
// Combinational 4-way round-robin selector: first eligible port after ptr.
module com_rr_arb4
  import com_slink_tx_arb_pkg::*;
(
  input  logic [PORT_NUM-1:0] elig,
  input  logic [1:0]          ptr,
  output logic [PORT_NUM-1:0] gnt
);

  logic [1:0] idx;
  logic       found;

  // Scan starting one past the last-served port, wrapping 3 -> 0
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= PORT_NUM; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/com_slink_tx_arb.sv
// Packet arbiter: round-robin selects one of four requesters and forwards
// its packet word by word to the SLINK transmitter, with an inter-packet
// gap and a watchdog that abandons a stalled requester.
//
//  state | meaning
//  IDLE  | no owner, waiting for an enabled non-empty requester
//  ARB   | pick next owner round-robin, register grant
//  XFER  | forward owner's words until EOP or watchdog expiry
//  GAP   | mandatory idle spacing before the next packet
module com_slink_tx_arb
  import com_slink_tx_arb_pkg::*;
#(
  parameter int GAP_CYC  = 8,
  parameter int TOUT_CYC = 1023
) (
  input  logic               clk_125m,
  input  logic               rst_125m,
  com_slink_tx_arb_if.slave  bus
);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_CYC - 1);

  arb_state_e          state_q, state_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [TOUT_W-1:0]   tout_q, tout_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [WORD_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_dval_q, tx_dval_d;
  logic                tx_eop_q, tx_eop_d;
  logic                arb_err_q, arb_err_d;

  logic [PORT_NUM-1:0] elig;
  logic [PORT_NUM-1:0] rr_gnt;
  logic [PORT_NUM-1:0] req_rdreq_c;
  logic [WORD_W-1:0]   g_word;
  logic                g_dval;

  assign elig = ~bus.req_empty & bus.port_en;

  com_rr_arb4 u_rr (
    .elig (elig),
    .ptr  (ptr_q),
    .gnt  (rr_gnt)
  );

  // Select the current owner's word and valid; other ports are never seen
  always_comb begin
    g_word = '0;
    g_dval = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (grant_q[i]) begin
        g_word = bus.req_data[i*WORD_W +: WORD_W];
        g_dval = bus.req_dval[i];
      end
    end
  end

  // Next-state, counters and output staging
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    tout_d      = tout_q;
    gap_d       = gap_q;
    tx_data_d   = tx_data_q;
    tx_dval_d   = 1'b0;
    tx_eop_d    = 1'b0;
    arb_err_d   = 1'b0;
    req_rdreq_c = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|elig) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (|rr_gnt) begin
          grant_d = rr_gnt;
          ptr_d   = oh_to_idx(rr_gnt);
          tout_d  = '0;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        req_rdreq_c = grant_q & {PORT_NUM{bus.tx_rdreq}};
        if (g_dval) begin
          // a word arriving on the expiry cycle still counts, so EOP beats abort
          tx_data_d = g_word;
          tx_dval_d = 1'b1;
          tout_d    = '0;
          if (g_word[EOP_BIT]) begin
            tx_eop_d = 1'b1;
            grant_d  = '0;
            gap_d    = '0;
            state_d  = ST_GAP;
          end
        end else if (tout_q >= TOUT_LAST) begin
          arb_err_d = 1'b1;
          grant_d   = '0;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else begin
          tout_d = (tout_q == '1) ? tout_q : tout_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q >= GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = (gap_q == '1) ? gap_q : gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; pointer starts at 3 so port 0 wins the first arbitration
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= 2'd3;
      tout_q    <= '0;
      gap_q     <= '0;
      tx_data_q <= '0;
      tx_dval_q <= 1'b0;
      tx_eop_q  <= 1'b0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      tout_q    <= tout_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_dval_q <= tx_dval_d;
      tx_eop_q  <= tx_eop_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign bus.req_rdreq = req_rdreq_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_dval   = tx_dval_q;
  assign bus.tx_eop    = tx_eop_q;
  assign bus.arb_err   = arb_err_q;
  assign bus.grant     = grant_q;
  assign bus.tx_empty  = (state_q != ST_XFER);

endmodule

// File: tb/tb_com_slink_tx_arb.sv
// Directed bench for com_slink_tx_arb with a simple packet-source model per port.
module tb_com_slink_tx_arb;
  import com_slink_tx_arb_pkg::*;

  localparam int GAP  = 8;
  localparam int TOUT = 16;

  logic clk_125m = 1'b0;
  logic rst_125m = 1'b0;
  always #4 clk_125m = ~clk_125m;

  com_slink_tx_arb_if bus ();

  com_slink_tx_arb #(.GAP_CYC(GAP), .TOUT_CYC(TOUT)) dut (
    .clk_125m (clk_125m),
    .rst_125m (rst_125m),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  int unsigned         len  [PORT_NUM];
  int unsigned         wptr [PORT_NUM];
  logic [PORT_NUM-1:0] stuck;
  logic [PORT_NUM-1:0] hold;
  logic [PORT_NUM-1:0] rd_pend;

  function automatic logic [WORD_W-1:0] mk_word(input int p, input int k, input int n);
    logic [WORD_W-1:0] w;
    w          = '0;
    w[SOP_BIT] = (k == 0);
    w[EOP_BIT] = (k == n - 1);
    w[15:0]    = {8'(p), 8'(k)};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_125m);
    #1;
  endtask

  // Requester read strobes are stable mid-cycle
  always @(negedge clk_125m) rd_pend = bus.req_rdreq;

  // Packet sources: answer a strobe one cycle later, stop after EOP until ungranted
  always @(posedge clk_125m) begin
    #1;
    if (!rst_125m) begin
      hold         = '0;
      bus.req_dval = '0;
      bus.req_data = '0;
      for (int i = 0; i < PORT_NUM; i++) wptr[i] = 0;
    end else begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (rd_pend[i] && !hold[i] && !stuck[i]) begin
          bus.req_dval[i] = 1'b1;
          bus.req_data[i*WORD_W +: WORD_W] = mk_word(i, int'(wptr[i]), int'(len[i]));
          if (wptr[i] == len[i] - 1) begin
            hold[i] = 1'b1;
            wptr[i] = 0;
          end else begin
            wptr[i] = wptr[i] + 1;
          end
        end else begin
          bus.req_dval[i] = 1'b0;
          bus.req_data[i*WORD_W +: WORD_W] = '0;
        end
        if (!bus.grant[i]) hold[i] = 1'b0;
      end
    end
  end

  initial begin
    int                cyc;
    int                n;
    int                cnt;
    int                run;
    int                gcount;
    int                words;
    int                eops;
    logic              ok;
    logic [3:0]        prev;
    logic [WORD_W-1:0] exp1 [3];
    logic [3:0]        expg [9];
    exp1 = '{18'h20200, 18'h00201, 18'h10202};
    expg = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h8, 4'h2, 4'h8};

    stuck         = '0;
    for (int i = 0; i < PORT_NUM; i++) len[i] = 2;
    bus.port_en   = 4'hF;
    bus.req_empty = 4'hF;
    bus.tx_rdreq  = 1'b1;
    repeat (3) step();

    // reset state, tx_rdreq high must be ignored
    chk("rst_grant",    32'(bus.grant),     32'h0);
    chk("rst_tx_empty", 32'(bus.tx_empty),  32'h1);
    chk("rst_tx_dval",  32'(bus.tx_dval),   32'h0);
    chk("rst_tx_data",  32'(bus.tx_data),   32'h0);
    chk("rst_rdreq",    32'(bus.req_rdreq), 32'h0);
    chk("rst_eop_err",  32'({bus.tx_eop, bus.arb_err}), 32'h0);

    // single 3-word packet on port 2
    len[2]        = 3;
    bus.req_empty = 4'b1011;
    rst_125m      = 1'b1;
    ok = 1'b0;
    for (cyc = 0; cyc < 10 && !ok; cyc++) begin
      step();
      if (bus.grant != 0) ok = 1'b1;
    end
    chk("t1_grant_seen", 32'(ok), 32'h1);
    chk("t1_grant",      32'(bus.grant),     32'h4);
    chk("t1_rdreq",      32'(bus.req_rdreq), 32'h4);
    chk("t1_tx_empty",   32'(bus.tx_empty),  32'h0);
    bus.req_empty = 4'hF;
    n  = 0;
    ok = 1'b0;
    for (cyc = 1; cyc <= 20 && !ok; cyc++) begin
      step();
      if (bus.tx_dval) begin
        if (n == 0) chk("t1_latency", 32'(cyc), 32'h2);
        if (n < 3) chk($sformatf("t1_word%0d", n), 32'(bus.tx_data), 32'(exp1[n]));
        else chk("t1_extra_word", 32'(n), 32'h2);
        n++;
      end
      if (bus.tx_eop) begin
        ok = 1'b1;
        chk("t1_eop_word_idx", 32'(n), 32'h3);
        chk("t1_grant_eop",    32'(bus.grant), 32'h0);
      end
    end
    chk("t1_eop_seen", 32'(ok), 32'h1);
    cnt = 0;
    for (int k = 0; k < GAP; k++) begin
      if (bus.tx_empty) cnt++;
      step();
    end
    chk("t1_empty_after", 32'(cnt), 32'(GAP));

    // all ports busy, 2-word packets: 0,1,2,3,0 then port_en=1010: 1,3,1,3
    rst_125m = 1'b0;
    repeat (2) step();
    len[2]        = 2;
    bus.req_empty = 4'h0;
    rst_125m      = 1'b1;
    gcount = 0;
    run    = 0;
    words  = 0;
    prev   = 4'h0;
    for (cyc = 0; cyc < 400 && gcount < 9; cyc++) begin
      step();
      if (bus.tx_dval) words++;
      if (bus.grant != 0 && prev == 0) begin
        chk($sformatf("t2_grant%0d", gcount), 32'(bus.grant), 32'(expg[gcount]));
        if (gcount > 0) begin
          chk($sformatf("t2_gap%0d", gcount),   32'(run >= GAP), 32'h1);
          chk($sformatf("t2_words%0d", gcount), 32'(words), 32'h2);
        end
        words = 0;
        gcount++;
        if (gcount == 5) bus.port_en = 4'b1010;
      end
      if (bus.tx_empty) run++;
      else run = 0;
      prev = bus.grant;
    end
    chk("t2_grant_count", 32'(gcount), 32'h9);

    // port 1 never answers: watchdog abort, then served after the gap
    rst_125m = 1'b0;
    repeat (2) step();
    bus.port_en   = 4'hF;
    bus.req_empty = 4'b1101;
    stuck[1]      = 1'b1;
    rst_125m      = 1'b1;
    ok = 1'b0;
    for (cyc = 0; cyc < 10 && !ok; cyc++) begin
      step();
      if (bus.grant != 0) ok = 1'b1;
    end
    chk("t3_grant", 32'(bus.grant), 32'h2);
    ok   = 1'b0;
    n    = 0;
    eops = 0;
    for (cyc = 1; cyc <= 40 && !ok; cyc++) begin
      step();
      if (bus.tx_dval) n++;
      if (bus.tx_eop) eops++;
      if (bus.arb_err) begin
        ok = 1'b1;
        chk("t3_err_cycle", 32'(cyc),       32'(TOUT));
        chk("t3_grant_err", 32'(bus.grant), 32'h0);
      end
    end
    chk("t3_err_seen", 32'(ok),   32'h1);
    chk("t3_no_words", 32'(n),    32'h0);
    chk("t3_no_eop",   32'(eops), 32'h0);
    step();
    chk("t3_err_pulse", 32'(bus.arb_err), 32'h0);
    stuck[1] = 1'b0;
    ok = 1'b0;
    for (cyc = 1; cyc <= 30 && !ok; cyc++) begin
      step();
      if (bus.grant != 0) ok = 1'b1;
    end
    chk("t3_regrant",  32'(bus.grant), 32'h2);
    chk("t3_regap",    32'(cyc >= GAP), 32'h1);
    bus.req_empty = 4'hF;
    n  = 0;
    ok = 1'b0;
    for (cyc = 1; cyc <= 20 && !ok; cyc++) begin
      step();
      if (bus.tx_dval) begin
        if (n == 0) chk("t3_first_sop", 32'(bus.tx_data), 32'h20100);
        n++;
      end
      if (bus.tx_eop) ok = 1'b1;
    end
    chk("t3_pkt_words", 32'(n), 32'h2);

    // 1-word packet on port 3 whose only word lands on the expiry cycle
    bus.tx_rdreq  = 1'b0;
    len[3]        = 1;
    bus.req_empty = 4'b0111;
    ok = 1'b0;
    for (cyc = 0; cyc < 30 && !ok; cyc++) begin
      step();
      if (bus.grant != 0) ok = 1'b1;
    end
    chk("t4_grant", 32'(bus.grant), 32'h8);
    bus.req_empty = 4'hF;
    repeat (14) step();
    chk("t4_still_xfer", 32'({bus.tx_empty, bus.arb_err}), 32'h0);
    bus.tx_rdreq = 1'b1;
    step();
    bus.tx_rdreq = 1'b0;
    step();
    chk("t4_eop",     32'({bus.tx_eop, bus.tx_dval}), 32'h3);
    chk("t4_no_err",  32'(bus.arb_err), 32'h0);
    chk("t4_data",    32'(bus.tx_data), 32'h30300);
    chk("t4_grant0",  32'(bus.grant),   32'h0);
    step();
    chk("t4_no_late_err", 32'(bus.arb_err), 32'h0);

    // asynchronous reset mid-packet on port 0, then a fresh packet
    rst_125m = 1'b0;
    repeat (2) step();
    len[0]        = 4;
    bus.req_empty = 4'b1110;
    bus.tx_rdreq  = 1'b1;
    rst_125m      = 1'b1;
    ok = 1'b0;
    for (cyc = 0; cyc < 20 && !ok; cyc++) begin
      step();
      if (bus.tx_dval) ok = 1'b1;
    end
    chk("t5_first_word", 32'(bus.tx_data), 32'h20000);
    step();
    #2;
    rst_125m = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(bus.grant),     32'h0);
    chk("t5_rst_dval",  32'(bus.tx_dval),   32'h0);
    chk("t5_rst_data",  32'(bus.tx_data),   32'h0);
    chk("t5_rst_flags", 32'({bus.tx_eop, bus.arb_err, bus.tx_empty}), 32'h1);
    chk("t5_rst_rdreq", 32'(bus.req_rdreq), 32'h0);
    repeat (2) step();
    rst_125m = 1'b1;
    ok = 1'b0;
    for (cyc = 0; cyc < 10 && !ok; cyc++) begin
      step();
      if (bus.grant != 0) ok = 1'b1;
    end
    chk("t5_regrant", 32'(bus.grant), 32'h1);
    n  = 0;
    ok = 1'b0;
    for (cyc = 1; cyc <= 20 && !ok; cyc++) begin
      step();
      if (bus.tx_dval) begin
        if (n == 0) chk("t5_fresh_sop", 32'(bus.tx_data), 32'h20000);
        n++;
      end
      if (bus.tx_eop) ok = 1'b1;
    end
    chk("t5_pkt_words", 32'(n), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/com_slink_tx_arb.md
COM_SLINK_TX_ARB -- requirements
Module: com_slink_tx_arb

Interface
REQ-001 Parameter GAP_CYC, default 8: idle cycles inserted between consecutive packets (range 1..255).
REQ-002 Parameter TOUT_CYC, default 1023: max cycles in XFER without a requester data word before abort (range 1..65535).
REQ-003 clk_125m  in  1  sole clock, 125 MHz; all logic on rising edge.
REQ-004 rst_125m  in  1  asynchronous, active-low reset.
REQ-005 port_en  in  4  per-requester enable; bit i = requester i.
REQ-006 req_empty  in  4  requester i has no complete packet queued when 1.
REQ-007 req_rdreq  out  4  read strobe to requester i.
REQ-008 req_data  in  72  requester i word at [18i+17:18i]; bit 17 = SOP, bit 16 = EOP, [15:0] payload.
REQ-009 req_dval  in  4  requester i word valid, 1 cycle after its req_rdreq.
REQ-010 tx_rdreq  in  1  read strobe from SLINK transmitter.
REQ-011 tx_data  out  18  word to transmitter, same bit layout as req_data.
REQ-012 tx_dval  out  1  tx_data valid.
REQ-013 tx_empty  out  1  no packet available to transmitter when 1.
REQ-014 grant  out  4  one-hot current owner; 0 when none.
REQ-015 tx_eop  out  1  1-cycle pulse when EOP word is forwarded.
REQ-016 arb_err  out  1  1-cycle pulse on timeout abort.

Function
REQ-017 FSM states: IDLE, ARB, XFER, GAP; one state per cycle minimum.
REQ-018 IDLE -> ARB when any (~req_empty & port_en) bit is 1; else stay IDLE.
REQ-019 ARB: round-robin select first eligible port after last-served pointer (wrap 3->0); register grant, update pointer, -> XFER next cycle.
REQ-020 ARB with no eligible port (dropped in same cycle) -> IDLE, grant stays 0.
REQ-021 XFER: req_rdreq[i] = tx_rdreq & grant[i], combinational; all other req_rdreq bits 0.
REQ-022 XFER: tx_data/tx_dval = granted req_data/req_dval registered, 1-cycle latency; tx_rdreq to tx_dval latency = 2 cycles.
REQ-023 XFER: tx_empty = 0; in IDLE, ARB, GAP tx_empty = 1 and tx_rdreq is ignored.
REQ-024 Forwarded word with EOP bit 1: tx_eop pulses with that word's tx_dval; state -> GAP; grant -> 0.
REQ-025 Timeout counter: clears on each granted req_dval, increments otherwise in XFER; at TOUT_CYC -> arb_err pulse, grant -> 0, -> GAP; no further words forwarded.
REQ-026 EOP word and timeout in same cycle: EOP wins, no arb_err.
REQ-027 port_en or req_empty change during XFER: no effect until packet end.
REQ-028 req_dval from non-granted port: ignored, never forwarded.
REQ-029 GAP: count GAP_CYC cycles, then -> IDLE; counters 8 bits (gap) and 16 bits (timeout), saturating never wrap.

Reset
REQ-030 On rst_125m low: state IDLE, grant 0, req_rdreq 0, tx_data 0, tx_dval 0, tx_eop 0, arb_err 0, tx_empty 1, counters 0.
REQ-031 Pointer resets to 3 so port 0 has first priority.
REQ-032 Reset mid-packet aborts silently; no arb_err, no tx_eop; partial packet not resumed.

Structure
REQ-033 Shared package holds SOP_BIT=17, EOP_BIT=16, PORT_NUM=4, word width 18, FSM state encoding.
REQ-034 One sub-module com_rr_arb4: combinational round-robin selector (eligible mask + pointer -> one-hot).

Verification
REQ-035 Reset release, port 2 non-empty with 3-word packet (SOP..EOP), tx_rdreq held 1 -> grant=4'b0100, 3 tx_dval words in order, tx_eop on third, tx_empty 1 for 8 cycles after.
REQ-036 All 4 ports non-empty continuously, 2-word packets -> grant sequence 0,1,2,3,0; each burst separated by >= GAP_CYC idle cycles.
REQ-037 Port 1 granted, req_dval stuck 0, TOUT_CYC=16 -> arb_err pulse after 16 cycles, grant=0, no tx_eop, next packet served after gap.
REQ-038 port_en=4'b1010 with all ports non-empty -> only ports 1 and 3 granted, alternating.
REQ-039 rst_125m asserted mid-packet on port 0 -> all outputs at reset values asynchronously; after release port 0 served from fresh SOP.
REQ-040 EOP arrives on exact timeout cycle -> tx_eop pulses, arb_err stays 0.
